// File: rtl/lcd_scanout_if.sv
// Framebuffer read port and LCD pixel stream shared by lcd_scanout and its consumer.
// master: the scanout engine (issues reads, drives pixels).
// slave:  the framebuffer/sink side (returns read data, drives pix_ready).
interface lcd_scanout_if #(
    parameter int ADDR_W = 15,
    parameter int PIX_W  = 2
);
    logic              fb_rd_en;
    logic [ADDR_W-1:0] fb_rd_addr;
    logic [PIX_W-1:0]  fb_rd_data;
    logic              pix_valid;
    logic              pix_ready;
    logic [PIX_W-1:0]  pix_data;
    logic              pix_sol;
    logic              pix_eol;
    logic              pix_eof;

    modport master (
        output fb_rd_en, fb_rd_addr,
        input  fb_rd_data,
        output pix_valid, pix_data, pix_sol, pix_eol, pix_eof,
        input  pix_ready
    );

    modport slave (
        input  fb_rd_en, fb_rd_addr,
        output fb_rd_data,
        input  pix_valid, pix_data, pix_sol, pix_eol, pix_eof,
        output pix_ready
    );
endinterface

// File: rtl/lcd_scanout.sv
// lcd_scanout: streams a WIDTHxHEIGHT framebuffer in raster order onto a
// valid/ready pixel stream after each frame_start pulse. Reads go through a
// 1-cycle-latency port; a 2-entry FIFO with registered head absorbs that
// latency so the stream runs at 1 pixel/clock with pix_ready high.
// Optional build macro LCD_SCANOUT_PALETTE_EN: map shades through bgp at the
// FIFO output. Without it bgp is ignored.
module lcd_scanout #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 144,
    parameter int PIX_W  = 2,
    parameter int ADDR_W = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         frame_start,
    input  logic [7:0]   bgp,
    output logic         busy,
    output logic         frame_done,
    lcd_scanout_if.master bus
);
    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)      : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT + 1) : 1;
    // FIFO entry: {eof, eol, sol, shade}
    localparam int EW = PIX_W + 3;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t            state_q;
    logic              busy_q, frame_done_q;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              inflight_q, inflight_d;
    logic [2:0]        side_q, side_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [EW-1:0]     head_q, head_d, skid_q, skid_d;

    logic              rd_en, pop, push, last_px, start_ok, pix_valid;
    logic              x_last;
    logic [2:0]        occ;
    logic [EW-1:0]     push_ent;

    assign start_ok  = (state_q == IDLE) && frame_start && !frame_done_q;
    assign x_last    = (x_q == XW'(WIDTH - 1));
    assign last_px   = x_last && (y_q == YW'(HEIGHT - 1));
    assign pix_valid = (cnt_q != 2'd0);
    assign pop       = pix_valid && bus.pix_ready;
    assign push      = inflight_q;
    assign push_ent  = {side_q, bus.fb_rd_data};

    // Read issue: never let buffered + in-flight pixels exceed the 2 FIFO slots.
    always_comb begin
        occ   = {1'b0, cnt_q} + {2'b0, inflight_q} - {2'b0, pop};
        rd_en = (state_q == FETCH) && (occ < 3'd2);
    end

    // Raster counters and read address; frozen on the final pixel so the
    // address holds the last one read once the frame is fetched.
    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        addr_d     = addr_q;
        side_d     = side_q;
        inflight_d = rd_en;
        if (start_ok) begin
            x_d    = '0;
            y_d    = '0;
            addr_d = '0;
        end else if (rd_en) begin
            side_d = {last_px, x_last, (x_q == '0)};
            if (!last_px) begin
                addr_d = addr_q + 1'b1;
                if (x_last) begin
                    x_d = '0;
                    y_d = y_q + 1'b1;
                end else begin
                    x_d = x_q + 1'b1;
                end
            end
        end
    end

    // Two-entry FIFO: head is the presented pixel, skid catches the read
    // that lands while the head is stalled.
    always_comb begin
        head_d = head_q;
        skid_d = skid_q;
        cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
        if (pop) begin
            if (cnt_q == 2'd2) begin
                head_d = skid_q;
                if (push) skid_d = push_ent;
            end else if (push) begin
                head_d = push_ent;
            end
        end else if (push) begin
            if (cnt_q == 2'd0) head_d = push_ent;
            else               skid_d = push_ent;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q        <= '0;
            y_q        <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            side_q     <= '0;
            cnt_q      <= '0;
            head_q     <= '0;
            skid_q     <= '0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            addr_q     <= addr_d;
            inflight_q <= inflight_d;
            side_q     <= side_d;
            cnt_q      <= cnt_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
        end
    end

    // Control FSM with registered busy/frame_done; done fires the cycle after
    // the FIFO is known to go empty with nothing in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        state_q <= FETCH;
                        busy_q  <= 1'b1;
                    end
                end
                FETCH: begin
                    if (rd_en && last_px) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (cnt_d == 2'd0 && !inflight_d) begin
                        state_q      <= IDLE;
                        busy_q       <= 1'b0;
                        frame_done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy           = busy_q;
    assign frame_done     = frame_done_q;
    assign bus.fb_rd_en   = rd_en;
    assign bus.fb_rd_addr = addr_q;
    assign bus.pix_valid  = pix_valid;
    assign bus.pix_sol    = pix_valid && head_q[PIX_W];
    assign bus.pix_eol    = pix_valid && head_q[PIX_W+1];
    assign bus.pix_eof    = pix_valid && head_q[PIX_W+2];

`ifdef LCD_SCANOUT_PALETTE_EN
    // Palette lookup on the presented pixel; bgp changes apply immediately.
    logic [1:0] pal_sh;
    assign pal_sh       = bgp[{head_q[1:0], 1'b0} +: 2];
    assign bus.pix_data = pix_valid ? PIX_W'(pal_sh) : '0;
`else
    logic unused_bgp;
    assign unused_bgp   = ^bgp;
    assign bus.pix_data = pix_valid ? head_q[PIX_W-1:0] : '0;
`endif

endmodule
